// File: rtl/branch_resolver.sv
// EX-stage branch resolver: checks the IF prediction, redirects and flushes on a mispredict,
// squashes wrong-path slots and writes the BTB. Statistics counters are enabled by BRU_STATS_EN.

module branch_resolver_chk #(
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    input logic        squashing,
    input logic        redirect_valid,
    input logic [31:0] redirect_pc
);
    generate
        if (SQUASH_CYCLES == 0) begin : g_bad_squash_cycles
            $error("branch_resolver: SQUASH_CYCLES must be at least 1");
        end
    endgenerate

    a_pc_zero_when_idle: assert property (@(posedge clk) disable iff (rst)
        (!redirect_valid |-> (redirect_pc == 32'd0)));

    a_no_redirect_in_squash: assert property (@(posedge clk) disable iff (rst)
        (squashing |-> !redirect_valid));
endmodule

module branch_resolver #(
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             ex_actual_taken,
    input  logic [31:0]      ex_actual_target,
    output logic             update_en,
    output logic [31:0]      pc_update,
    output logic [31:0]      actual_target,
    output logic             actual_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int unsigned SQ_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYCLES - 1);
    localparam logic [SQ_W-1:0] SQ_ZERO = {SQ_W{1'b0}};
    localparam logic [SQ_W-1:0] SQ_ONE  = SQ_W'(1'b1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [SQ_W-1:0] sq_cnt_r, sq_cnt_s;
    logic            done_r, done_s;
    logic            pend_r, pend_s;
    logic            ctl_s, taken_s, mispredict_s;
    logic [31:0]     redirect_pc_s;

    logic            upd_en_r;
    logic [31:0]     pc_update_r;
    logic [31:0]     actual_target_r;
    logic            actual_taken_r;

    // Resolve the EX instruction against its IF-time prediction.
    always_comb begin
        ctl_s         = ex_valid & (ex_is_branch | ex_is_jump) & (state_r == ST_IDLE) & ~done_r;
        taken_s       = ex_is_jump | ex_actual_taken;
        mispredict_s  = 1'b0;
        redirect_pc_s = 32'd0;
        if (ctl_s) begin
            mispredict_s = (taken_s != ex_pred_taken) |
                           (taken_s & ex_pred_taken & (ex_actual_target != ex_pred_target));
        end else begin
            mispredict_s = 1'b0;
        end
        if (mispredict_s) begin
            redirect_pc_s = taken_s ? ex_actual_target : (ex_pc + 32'd4);
        end else begin
            redirect_pc_s = 32'd0;
        end
    end

    assign redirect_valid = mispredict_s;
    assign redirect_pc    = redirect_pc_s;
    assign flush_if_id    = mispredict_s;
    assign flush_id_ex    = mispredict_s;

    // Next-state logic; a mispredict seen under stall is parked in pend until EX moves on.
    always_comb begin
        state_s  = state_r;
        sq_cnt_s = sq_cnt_r;
        done_s   = stall ? (done_r | ctl_s) : 1'b0;
        pend_s   = stall ? (pend_r | mispredict_s) : 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((mispredict_s | pend_r) & ~stall) begin
                    state_s  = ST_SQUASH;
                    sq_cnt_s = SQ_LOAD;
                end else begin
                    state_s  = ST_IDLE;
                    sq_cnt_s = sq_cnt_r;
                end
            end
            ST_SQUASH: begin
                if (stall) begin
                    state_s  = ST_SQUASH;
                    sq_cnt_s = sq_cnt_r;
                end else if (sq_cnt_r == SQ_ZERO) begin
                    state_s  = ST_IDLE;
                    sq_cnt_s = SQ_ZERO;
                end else begin
                    state_s  = ST_SQUASH;
                    sq_cnt_s = sq_cnt_r - SQ_ONE;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                sq_cnt_s = SQ_ZERO;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            sq_cnt_r <= SQ_ZERO;
            done_r   <= 1'b0;
            pend_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            sq_cnt_r <= sq_cnt_s;
            done_r   <= done_s;
            pend_r   <= pend_s;
        end
    end

    // BTB write port: one-cycle strobe after each resolution, data held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_en_r        <= 1'b0;
            pc_update_r     <= 32'd0;
            actual_target_r <= 32'd0;
            actual_taken_r  <= 1'b0;
        end else if (ctl_s) begin
            upd_en_r        <= 1'b1;
            pc_update_r     <= ex_pc;
            actual_target_r <= ex_actual_target;
            actual_taken_r  <= taken_s;
        end else begin
            upd_en_r        <= 1'b0;
            pc_update_r     <= pc_update_r;
            actual_target_r <= actual_target_r;
            actual_taken_r  <= actual_taken_r;
        end
    end

    // A reset landing in the cycle after a resolution must not leak a write to the BTB.
    assign update_en     = upd_en_r & ~rst;
    assign pc_update     = pc_update_r;
    assign actual_target = actual_target_r;
    assign actual_taken  = actual_taken_r;

`ifdef BRU_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] br_cnt_r;
    logic [CNT_W-1:0] mp_cnt_r;

    // Saturating resolution and mispredict counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_r <= {CNT_W{1'b0}};
            mp_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (ctl_s && (br_cnt_r != CNT_MAX)) begin
                br_cnt_r <= br_cnt_r + CNT_ONE;
            end else begin
                br_cnt_r <= br_cnt_r;
            end
            if (mispredict_s && (mp_cnt_r != CNT_MAX)) begin
                mp_cnt_r <= mp_cnt_r + CNT_ONE;
            end else begin
                mp_cnt_r <= mp_cnt_r;
            end
        end
    end

    assign branch_count     = br_cnt_r;
    assign mispredict_count = mp_cnt_r;
`else
    assign branch_count     = {CNT_W{1'b0}};
    assign mispredict_count = {CNT_W{1'b0}};
`endif

    branch_resolver_chk #(
        .SQUASH_CYCLES (SQUASH_CYCLES)
    ) u_chk (
        .clk            (clk),
        .rst            (rst),
        .squashing      (state_r == ST_SQUASH),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );
endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model kept here.

module tb_branch_resolver;
    localparam int SQ = 2;
`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, ex_valid, ex_is_branch, ex_is_jump;
    logic [31:0] ex_pc, ex_pred_target, ex_actual_target;
    logic        ex_pred_taken, ex_actual_taken;
    logic        update_en, actual_taken, redirect_valid, flush_if_id, flush_id_ex;
    logic [31:0] pc_update, actual_target, redirect_pc;
    logic [31:0] branch_count, mispredict_count;

    branch_resolver #(.SQUASH_CYCLES(SQ), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_actual_taken(ex_actual_taken), .ex_actual_target(ex_actual_target),
        .update_en(update_en), .pc_update(pc_update), .actual_target(actual_target),
        .actual_taken(actual_taken), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_redir = 0;
    int n_upd = 0;

    // Reference model: slots still to ignore, held-instruction guard, owed squash window.
    int          m_ignore = 0;
    bit          m_held = 1'b0;
    bit          m_owed = 1'b0;
    bit          m_upd = 1'b0;
    logic [31:0] m_pc = 32'd0, m_tgt = 32'd0;
    bit          m_tk = 1'b0;
    logic [31:0] m_bc = 32'd0, m_mc = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit v, input bit br, input bit j,
                        input logic [31:0] pc, input bit pt, input logic [31:0] ptg,
                        input bit at, input logic [31:0] atg);
        bit          ctl, tk, mis;
        logic [31:0] rpc;
        rst = r; stall = s; ex_valid = v; ex_is_branch = br; ex_is_jump = j;
        ex_pc = pc; ex_pred_taken = pt; ex_pred_target = ptg;
        ex_actual_taken = at; ex_actual_target = atg;
        tk  = j || at;
        ctl = v && (br || j) && (m_ignore == 0) && !m_held;
        mis = ctl && ((tk != pt) || (tk && pt && (atg != ptg)));
        rpc = mis ? (tk ? atg : pc + 32'd4) : 32'd0;
        @(negedge clk);
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mis});
        chk("redirect_pc", redirect_pc, rpc);
        chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, mis});
        chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, mis});
        chk("update_en_live", {31'd0, update_en}, {31'd0, (m_upd && !r)});
        if (redirect_valid) n_redir++;
        if (r) begin
            m_ignore = 0; m_held = 1'b0; m_owed = 1'b0; m_upd = 1'b0;
            m_pc = 32'd0; m_tgt = 32'd0; m_tk = 1'b0; m_bc = 32'd0; m_mc = 32'd0;
        end else begin
            m_upd = ctl;
            if (ctl) begin
                m_pc = pc; m_tgt = atg; m_tk = tk;
                if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
                if (mis && (m_mc != 32'hFFFF_FFFF)) m_mc = m_mc + 32'd1;
            end
            if (m_ignore > 0) begin
                if (!s) m_ignore = m_ignore - 1;
            end else if ((mis || m_owed) && !s) begin
                m_ignore = SQ;
            end
            m_owed = s && (m_owed || mis);
            m_held = s && (m_held || ctl);
        end
        @(posedge clk);
        #1;
        chk("update_en", {31'd0, update_en}, {31'd0, m_upd});
        chk("pc_update", pc_update, m_pc);
        chk("actual_target", actual_target, m_tgt);
        chk("actual_taken", {31'd0, actual_taken}, {31'd0, m_tk});
        chk("branch_count", branch_count, STATS ? m_bc : 32'd0);
        chk("mispredict_count", mispredict_count, STATS ? m_mc : 32'd0);
        if (update_en) n_upd++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        int r0, u0;
        bit hold;
        bit r, s, v, br, j, pt, at;
        logic [31:0] pc, ptg, atg;
        int kind;

        do_reset();
        chk("reset_update_en", {31'd0, update_en}, 32'd0);
        chk("reset_pc_update", pc_update, 32'd0);

        // Correct not-taken branch
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'd0, 1'b0, 32'h104);
        chk("nt_upd_pc", pc_update, 32'h100);
        chk("nt_upd_taken", {31'd0, actual_taken}, 32'd0);
        idle(1);

        // Taken branch predicted not-taken, then wrong-path branches inside the window
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 32'd0, 1'b1, 32'h240);
        chk("tk_upd_target", actual_target, 32'h240);
        r0 = n_redir; u0 = n_upd;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h600, 1'b0, 32'd0, 1'b1, 32'h640);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h604, 1'b0, 32'd0, 1'b1, 32'h644);
        chk("squash_no_redirect", n_redir - r0, 32'd0);
        chk("squash_no_update", n_upd - u0, 32'd0);

        // Predicted taken, actually not taken; including PC wrap
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 1'b1, 32'h340, 1'b0, 32'h340);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h340, 1'b0, 32'h340);
        idle(2);

        // JAL with wrong target, then the same JAL correctly predicted
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4F0, 1'b1, 32'h500, 1'b0, 32'h580);
        chk("jal_upd_taken", {31'd0, actual_taken}, 32'd1);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4F0, 1'b1, 32'h580, 1'b0, 32'h580);
        chk("jal_ok_update", {31'd0, update_en}, 32'd1);
        idle(1);

        // Mispredict held by a 3-cycle stall
        r0 = n_redir; u0 = n_upd;
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h700, 1'b0, 32'd0, 1'b1, 32'h780);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700, 1'b0, 32'd0, 1'b1, 32'h780);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h704, 1'b0, 32'd0, 1'b1, 32'h790);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h708, 1'b0, 32'd0, 1'b1, 32'h790);
        chk("stall_redirect_pulses", n_redir - r0, 32'd1);
        chk("stall_update_pulses", n_upd - u0, 32'd1);
        idle(1);

        // Reset in the cycle after a mispredict, then an immediate mispredict is accepted
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h800, 1'b0, 32'd0, 1'b1, 32'h880);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        r0 = n_redir;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h900, 1'b0, 32'd0, 1'b1, 32'h980);
        chk("post_reset_redirect", n_redir - r0, 32'd1);

        // Five branches, two mispredicts
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA00, 1'b0, 32'd0, 1'b0, 32'hA40);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA04, 1'b0, 32'd0, 1'b1, 32'hA40);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA40, 1'b1, 32'hA80, 1'b1, 32'hA80);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA80, 1'b0, 32'd0, 1'b0, 32'hB00);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB00, 1'b0, 32'd0, 1'b0, 32'hB40);
        chk("stats_branches", branch_count, STATS ? 32'd5 : 32'd0);
        chk("stats_mispredicts", mispredict_count, STATS ? 32'd2 : 32'd0);

        // Random traffic; stalled instructions are re-presented unchanged
        hold = 1'b0;
        v = 1'b0; br = 1'b0; j = 1'b0; pt = 1'b0; at = 1'b0;
        pc = 32'd0; ptg = 32'd0; atg = 32'd0;
        for (int i = 0; i < 800; i++) begin
            if (!hold) begin
                v    = ($urandom_range(0, 3) != 0);
                kind = $urandom_range(0, 3);
                br   = (kind == 1) || (kind == 2);
                j    = (kind == 3);
                pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
                at   = $urandom_range(0, 1);
                pt   = $urandom_range(0, 1);
                atg  = $urandom & 32'hFFFF_FFFC;
                ptg  = ($urandom_range(0, 2) != 0) ? atg : ($urandom & 32'hFFFF_FFFC);
            end
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 3) == 0);
            if (r) v = 1'b0;
            step(r, s, v, br, j, pc, pt, ptg, at, atg);
            hold = s && !r;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
